// File: rtl/osd_tep_scheduler.sv
// OSD TEP scheduler: issues order-0/1/2 test error patterns, keeps the best score.
// Define OSD_EARLY_STOP_EN to stop issuing once a score reaches stop_thresh.
`timescale 1ns/1ps
module osd_tep_scheduler #(
  parameter int K           = 32,
  parameter int SCORE_WIDTH = 12,
  parameter int DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          tep_valid,
  input  logic                          tep_ready,
  output logic [1:0]                    tep_order,
  output logic [$clog2(K)-1:0]          tep_i,
  output logic [$clog2(K)-1:0]          tep_j,
  output logic                          tep_last,
  input  logic                          score_valid,
  input  logic signed [SCORE_WIDTH-1:0] score,
  output logic [1:0]                    best_order,
  output logic [$clog2(K)-1:0]          best_i,
  output logic [$clog2(K)-1:0]          best_j,
  output logic signed [SCORE_WIDTH-1:0] best_score,
  input  logic signed [SCORE_WIDTH-1:0] stop_thresh,
  output logic                          early_stop,
  output logic                          protocol_err,
  output logic [15:0]                   tep_count
);
  localparam int IW = $clog2(K);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = 2 + 2 * IW;
  localparam logic [IW-1:0] I_LAST = IW'(K - 2);
  localparam logic [IW-1:0] J_LAST = IW'(K - 1);
  localparam logic signed [SCORE_WIDTH-1:0] S_MAX =
    {1'b0, {(SCORE_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_n;

  logic [TW-1:0] fifo [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tag;
  logic          have_best, fire, pop, stop_hit, in_run;
  logic [1:0]    order_n;
  logic [IW-1:0] i_n, j_n;

  assign in_run    = (state == ISSUE) || (state == DRAIN);
  assign busy      = in_run;
  assign done      = (state == DONE);
  assign tep_valid = (state == ISSUE) && (cnt != CW'(DEPTH));
  assign tep_last  = (tep_order == 2'd2) && (tep_i == I_LAST)
                  && (tep_j == J_LAST);
  assign fire      = tep_valid && tep_ready;
  assign pop       = score_valid && in_run && (cnt != '0);
  assign tag       = fifo[rd_ptr];

`ifdef OSD_EARLY_STOP_EN
  assign stop_hit = pop && (state == ISSUE) && (score <= stop_thresh);
`else
  logic unused_thresh;
  assign unused_thresh = ^stop_thresh;
  assign stop_hit      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = ISSUE;
      ISSUE:   if ((fire && tep_last) || stop_hit) state_n = DRAIN;
      DRAIN:   if (cnt == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pattern successor: order 1 walks i, order 2 walks j inside i.
  always_comb begin
    order_n = tep_order;
    i_n     = tep_i;
    j_n     = tep_j;
    unique case (1'b1)
      tep_order == 2'd0: begin
        order_n = 2'd1;
        i_n     = '0;
        j_n     = '0;
      end
      tep_order == 2'd1 && tep_i != J_LAST:
        i_n = tep_i + 1'b1;
      tep_order == 2'd1 && tep_i == J_LAST: begin
        order_n = 2'd2;
        i_n     = '0;
        j_n     = IW'(1);
      end
      tep_order == 2'd2 && tep_j != J_LAST:
        j_n = tep_j + 1'b1;
      tep_order == 2'd2 && tep_j == J_LAST: begin
        i_n = tep_i + 1'b1;
        j_n = tep_i + IW'(2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fire) fifo[wr_ptr] <= {tep_order, tep_i, tep_j};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tep_order    <= '0;
      tep_i        <= '0;
      tep_j        <= '0;
      best_order   <= '0;
      best_i       <= '0;
      best_j       <= '0;
      best_score   <= S_MAX;
      have_best    <= 1'b0;
      tep_count    <= '0;
      early_stop   <= 1'b0;
      protocol_err <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
    end else begin
      if (score_valid && !pop) protocol_err <= 1'b1;
      if (state == IDLE && start) begin
        tep_order  <= '0;
        tep_i      <= '0;
        tep_j      <= '0;
        best_order <= '0;
        best_i     <= '0;
        best_j     <= '0;
        best_score <= S_MAX;
        have_best  <= 1'b0;
        tep_count  <= '0;
        early_stop <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        cnt        <= '0;
      end else begin
        if (fire) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (tep_count != 16'hFFFF) tep_count <= tep_count + 16'd1;
          if (!tep_last) begin
            tep_order <= order_n;
            tep_i     <= i_n;
            tep_j     <= j_n;
          end
        end
        // Strict less-than: ties keep the earlier pattern.
        if (pop) begin
          rd_ptr    <= rd_ptr + 1'b1;
          have_best <= 1'b1;
          if (!have_best || score < best_score) begin
            {best_order, best_i, best_j} <= tag;
            best_score <= score;
          end
        end
        if (fire != pop) cnt <= fire ? cnt + 1'b1 : cnt - 1'b1;
        if (stop_hit) early_stop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_osd_tep_scheduler.sv
// Bench for osd_tep_scheduler: directed steps with random stalls/scores
// checked against a pattern-list and min-score reference model.
`timescale 1ns/1ps
module tb_osd_tep_scheduler;
  localparam int K     = 4;
  localparam int SW    = 12;
  localparam int DEPTH = 4;
  localparam int IW    = 2;
  localparam int NTEP  = 1 + K + K * (K - 1) / 2;
  localparam int SMAX  = 2047;

  typedef struct {int o; int i; int j;} pat_t;

  logic clk = 1'b0;
  logic rst, start, busy, done;
  logic tep_valid, tep_ready, tep_last;
  logic [1:0] tep_order, best_order;
  logic [IW-1:0] tep_i, tep_j, best_i, best_j;
  logic score_valid;
  logic signed [SW-1:0] score, best_score, stop_thresh;
  logic early_stop, protocol_err;
  logic [15:0] tep_count;

  int total = 0;
  int bad = 0;
  pat_t exp_pats[$];
  int tbl[$];
  int mb_o, mb_i, mb_j, mb_s;
  bit m_have, m_perr;

  osd_tep_scheduler #(.K(K), .SCORE_WIDTH(SW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .tep_valid(tep_valid), .tep_ready(tep_ready),
    .tep_order(tep_order), .tep_i(tep_i), .tep_j(tep_j),
    .tep_last(tep_last), .score_valid(score_valid), .score(score),
    .best_order(best_order), .best_i(best_i), .best_j(best_j),
    .best_score(best_score), .stop_thresh(stop_thresh),
    .early_stop(early_stop), .protocol_err(protocol_err),
    .tep_count(tep_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_have = 0;
    mb_o = 0; mb_i = 0; mb_j = 0; mb_s = SMAX;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; start = 0; tep_ready = 0; score_valid = 0; score = '0;
    @(negedge clk);
    rst = 0;
    m_perr = 0;
    model_clear();
  endtask

  task automatic check_reset(input string p);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_valid"}, tep_valid, 0);
    chk({p, "_last"}, tep_last, 0);
    chk({p, "_early"}, early_stop, 0);
    chk({p, "_perr"}, protocol_err, 0);
    chk({p, "_count"}, tep_count, 0);
    chk({p, "_order"}, tep_order, 0);
    chk({p, "_i"}, tep_i, 0);
    chk({p, "_j"}, tep_j, 0);
    chk({p, "_best_o"}, best_order, 0);
    chk({p, "_best_i"}, best_i, 0);
    chk({p, "_best_j"}, best_j, 0);
    chk({p, "_best_s"}, best_score, SMAX);
  endtask

  task automatic check_best(input string p);
    chk({p, "_best_o"}, best_order, mb_o);
    chk({p, "_best_i"}, best_i, mb_i);
    chk({p, "_best_j"}, best_j, mb_j);
    chk({p, "_best_s"}, best_score, mb_s);
  endtask

  // One decode: start, then cycle-by-cycle drive and check against the model.
  task automatic run_decode(input bit rnd, input int lmin, input int lmax,
                            input int hold);
    pat_t pq[$];
    int dq[$];
    pat_t p;
    int issued = 0, last_due = 0, due, val;
    bit stopped = 0, issuing, fire, stop_now, drain_empty = 0, seen = 0;
    @(negedge clk);
    start = 1; score_valid = 0; tep_ready = 0;
    @(negedge clk);
    start = 0;
    model_clear();
    for (int c = 1; c <= 2000; c++) begin
      if (c > 1) @(negedge clk);
      issuing = !stopped && issued < NTEP;
      chk("done", done, drain_empty);
      chk("busy", busy, !drain_empty);
      chk("tep_valid", tep_valid, issuing && pq.size() < DEPTH);
      chk("tep_count", tep_count, issued);
      chk("early_stop", early_stop, stopped);
      chk("protocol_err", protocol_err, m_perr);
      if (hold > 0 && c == hold) chk("hold_count", tep_count, DEPTH);
      if (hold > 0 && c == hold + 5) chk("hold_one", tep_count, DEPTH + 1);
      if (issuing && tep_valid) begin
        chk("tep_order", tep_order, exp_pats[issued].o);
        chk("tep_i", tep_i, exp_pats[issued].i);
        chk("tep_j", tep_j, exp_pats[issued].j);
        chk("tep_last", tep_last, issued == NTEP - 1);
      end
      drain_empty = !issuing && pq.size() == 0;
      if (done) begin
        seen = 1;
        break;
      end
      tep_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      fire = issuing && pq.size() < DEPTH && tep_ready;
      score_valid = 0;
      stop_now = 0;
      if (dq.size() > 0 && dq[0] <= c) begin
        if (tbl.size() > 0) val = tbl.pop_front();
        else val = int'($urandom_range(400, 0)) - 200;
        score_valid = 1;
        score = SW'(val);
        p = pq.pop_front();
        void'(dq.pop_front());
        if (!m_have || val < mb_s) begin
          m_have = 1;
          mb_o = p.o; mb_i = p.i; mb_j = p.j; mb_s = val;
        end
`ifdef OSD_EARLY_STOP_EN
        if (issuing && val <= int'(stop_thresh)) stop_now = 1;
`endif
      end
      if (fire) begin
        pq.push_back(exp_pats[issued]);
        due = c + 1 + int'($urandom_range(lmax, lmin));
        if (due <= last_due) due = last_due + 1;
        if (hold > 0 && issued == 0 && due < hold) due = hold;
        if (hold > 0 && issued > 0 && due < hold + 6) due = hold + 6;
        last_due = due;
        dq.push_back(due);
        issued++;
      end
      stopped = stopped | stop_now;
    end
    tep_ready = 0;
    score_valid = 0;
    chk("done_seen", seen, 1);
    check_best("end");
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
    check_best("hold");
  endtask

  initial begin
    rst = 1; start = 0; tep_ready = 0; score_valid = 0;
    score = '0; stop_thresh = -12'sd2048;
    exp_pats.push_back('{0, 0, 0});
    for (int i = 0; i < K; i++) exp_pats.push_back('{1, i, 0});
    for (int i = 0; i < K; i++)
      for (int j = i + 1; j < K; j++) exp_pats.push_back('{2, i, j});

    do_reset();
    check_reset("rst");

    // Fixed scores, latency 2: minimum at (1,2), equal 7 keeps (1,0).
    tbl = '{9, 7, 7, 3, 5, 8, 6, 4, 10, 11, 12};
    run_decode(0, 1, 1, 0);
    chk("tbl_count", tep_count, NTEP);
    chk("tbl_best_o", best_order, 1);
    chk("tbl_best_i", best_i, 2);
    chk("tbl_best_j", best_j, 0);
    chk("tbl_best_s", best_score, 3);

    // Stray score in IDLE.
    @(negedge clk);
    score_valid = 1; score = -12'sd5;
    @(negedge clk);
    score_valid = 0; m_perr = 1;
    chk("idle_perr", protocol_err, 1);
    check_best("idle");
    do_reset();
    chk("perr_clr", protocol_err, 0);

    // Scores withheld: DEPTH issues, then one per returned score.
    run_decode(0, 0, 2, 8);
    for (int n = 0; n < 3; n++) run_decode(1, 0, 3, 0);

    // Reset in the middle of issuing.
    @(negedge clk);
    start = 1; tep_ready = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check_reset("mid");
    rst = 0; tep_ready = 0;
    @(negedge clk);
    score_valid = 1; score = 12'sd1;
    @(negedge clk);
    score_valid = 0;
    chk("post_rst_perr", protocol_err, 1);
    chk("post_rst_best", best_score, SMAX);
    do_reset();

`ifdef OSD_EARLY_STOP_EN
    stop_thresh = 12'sd2;
    tbl = '{9, 7, 1, 5, 6};
    run_decode(0, 1, 1, 0);
    chk("es_flag", early_stop, 1);
    chk("es_best_s", best_score, 1);
`else
    stop_thresh = 12'sd2047;
    run_decode(1, 0, 2, 0);
    chk("nes_flag", early_stop, 0);
    chk("nes_count", tep_count, NTEP);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
